// File: rtl/lif_scheduler.sv
// lif_scheduler: one shared leaky integrate-and-fire datapath swept across
// NUM_NEURONS virtual neurons per timestep tick. Spikes leave as valid/ready
// events tagged with the neuron index. Membranes and input currents are
// held in small register files.
module lif_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 8,
  parameter int THRESH      = 128,
  parameter int BETA_SHIFT  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           cur_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cur_addr,
  input  logic [W-1:0]                   cur_data,
  output logic                           spike_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] spike_id,
  input  logic                           spike_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun,
  input  logic [$clog2(NUM_NEURONS)-1:0] state_addr,
  output logic [W-1:0]                   state_data
);

  localparam int AW = $clog2(NUM_NEURONS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_NEURONS - 1);
  localparam logic [W:0]    THRESH_EXT = (W+1)'(THRESH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_spike_valid;
  logic [AW-1:0] r_spike_id;
  logic          r_overrun;

  logic [W-1:0]  r_mem [NUM_NEURONS];
  logic [W-1:0]  r_cur [NUM_NEURONS];

  logic [W-1:0]  w_m;
  logic [W-1:0]  w_leak;
  logic [W-1:0]  w_decayed;
  logic [W-1:0]  w_cur;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_sat;
  logic          w_fire;
  logic          w_mem_we;
  logic [W-1:0]  w_mem_wdata;

  // Shared update datapath for the neuron under the pointer. The leak never
  // exceeds m, so the decayed value cannot underflow; the sum gets one extra
  // bit so overflow can be clamped instead of wrapping.
  assign w_m         = r_mem[r_ptr];
  assign w_leak      = w_m >> BETA_SHIFT;
  assign w_decayed   = w_m - w_leak;
  assign w_cur       = r_cur[r_ptr];
  assign w_sum       = {1'b0, w_decayed} + {1'b0, w_cur};
  assign w_sat       = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  assign w_fire      = ({1'b0, w_sat} >= THRESH_EXT);
  assign w_mem_we    = (r_state == S_UPDATE);
  assign w_mem_wdata = w_fire ? '0 : w_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
      // Current register: host writes land at the edge in any FSM state, so
      // an update in the same cycle still sees the previous value.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cur[gi] <= '0;
        end else if (cur_we && (cur_addr == AW'(gi))) begin
          r_cur[gi] <= cur_data;
        end
      end

      // Membrane register: written only in the UPDATE cycle of this neuron.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (w_mem_we && (r_ptr == AW'(gi))) begin
          r_mem[gi] <= w_mem_wdata;
        end
      end
    end
  endgenerate

  // Sweep sequencer: walks the pointer, parks in EMIT while a spike waits
  // for the consumer, and flags ticks that arrive while a sweep is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            r_state <= S_UPDATE;
            r_ptr   <= '0;
          end
        end
        S_UPDATE: begin
          if (w_fire) begin
            r_spike_valid <= 1'b1;
            r_spike_id    <= r_ptr;
            r_state       <= S_EMIT;
          end else if (r_ptr == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        S_EMIT: begin
          if (spike_ready) begin
            r_spike_valid <= 1'b0;
            if (r_ptr == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_ptr   <= r_ptr + AW'(1);
              r_state <= S_UPDATE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign overrun     = r_overrun;
  assign state_data  = r_mem[state_addr];

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: a behavioural LIF model predicts
// each sweep, expected spike ids are queued up front and popped as the DUT
// hands spikes over, then sweep length, flags and membranes are compared.
module tb_lif_scheduler;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int THRESH = 128;
  localparam int BS     = 2;
  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       cur_we;
  logic [1:0] cur_addr;
  logic [7:0] cur_data;
  logic       spike_valid;
  logic [1:0] spike_id;
  logic       spike_ready;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [1:0] state_addr;
  logic [7:0] state_data;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   m_model   [N];
  int   cur_model [N];
  int   sb_ids    [$];
  logic exp_ovr;

  lif_scheduler #(
    .NUM_NEURONS(N),
    .W          (W),
    .THRESH     (THRESH),
    .BETA_SHIFT (BS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .cur_we     (cur_we),
    .cur_addr   (cur_addr),
    .cur_data   (cur_data),
    .spike_valid(spike_valid),
    .spike_id   (spike_id),
    .spike_ready(spike_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .state_addr (state_addr),
    .state_data (state_data)
  );

  always #5 clk = ~clk;

  // advance one clock; return 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cur(input int a, input int d);
    cur_we   = 1'b1;
    cur_addr = 2'(a);
    cur_data = 8'(d);
    step();
    cur_we = 1'b0;
    cur_model[a] = d;
    $display("[TB] write cur[%0d] = %0d", a, d);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_model[i]   = 0;
      cur_model[i] = 0;
    end
    sb_ids.delete();
    exp_ovr = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    tick = 1'b0;
    cur_we = 1'b0;
    repeat (ncyc) step();
    rst = 1'b0;
    clear_model();
  endtask

  // Predict one full sweep from the behavioural equations.
  task automatic model_sweep(output int nspk);
    int m, leak, s;
    nspk = 0;
    for (int i = 0; i < N; i++) begin
      m    = m_model[i];
      leak = m >> BS;
      s    = (m - leak) + cur_model[i];
      if (s > 255) s = 255;
      if (s >= THRESH) begin
        m_model[i] = 0;
        sb_ids.push_back(i);
        nspk++;
      end else begin
        m_model[i] = s;
      end
    end
  endtask

  task automatic check_membranes(input string name);
    for (int i = 0; i < N; i++) begin
      state_addr = 2'(i);
      #1;
      tests_run++;
      if (state_data !== 8'(m_model[i])) begin
        tests_failed++;
        $display("FAIL %s membrane[%0d]: got %0d expected %0d", name, i, state_data, m_model[i]);
      end
    end
  endtask

  // One tick-started sweep. stall = cycles of held-off ready per spike;
  // tick_at / wr_at inject a tick or a current write at sweep cycle k
  // (cycle 1 is the first UPDATE); probe_addr >= 0 watches that membrane
  // stay unchanged while a spike is stalled.
  task automatic run_sweep(input string name, input int stall, input int tick_at,
                           input int wr_at, input int wr_addr, input int wr_data,
                           input int probe_addr);
    int nspk, exp_cyc, done_cyc, k, hold, probe_val;
    done_cyc  = -1;
    hold      = 0;
    probe_val = (probe_addr >= 0) ? m_model[probe_addr] : 0;
    model_sweep(nspk);
    exp_cyc = N + 1 + nspk * (1 + stall);
    spike_ready = (stall == 0);
    if (probe_addr >= 0) state_addr = 2'(probe_addr);
    tick = 1'b1;
    step();
    tick = 1'b0;
    k = 1;
    while (done_cyc < 0 && k <= BUDGET) begin
      tick     = (k == tick_at);
      cur_we   = (k == wr_at);
      cur_addr = 2'(wr_addr);
      cur_data = 8'(wr_data);
      if (k == wr_at) cur_model[wr_addr] = wr_data;
      if (done) done_cyc = k;
      if (spike_valid) begin
        if (sb_ids.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL %s unexpected spike: got id %0d expected none", name, spike_id);
          spike_ready = 1'b1;
        end else begin
          tests_run++;
          if (spike_id !== 2'(sb_ids[0])) begin
            tests_failed++;
            $display("FAIL %s spike_id: got %0d expected %0d", name, spike_id, sb_ids[0]);
          end
          if (hold < stall) begin
            spike_ready = 1'b0;
            hold++;
            if (probe_addr >= 0) begin
              tests_run++;
              if (state_data !== 8'(probe_val)) begin
                tests_failed++;
                $display("FAIL %s stalled membrane[%0d]: got %0d expected %0d",
                         name, probe_addr, state_data, probe_val);
              end
            end
          end else begin
            spike_ready = 1'b1;
            $display("[TB] %s spike accepted id=%0d at cycle %0d", name, spike_id, k);
            void'(sb_ids.pop_front());
          end
        end
      end else begin
        hold = 0;
        spike_ready = (stall == 0);
      end
      step();
      k++;
    end
    tick = 1'b0;
    cur_we = 1'b0;
    spike_ready = 1'b1;

    tests_run++;
    if (done_cyc !== exp_cyc) begin
      tests_failed++;
      $display("FAIL %s done cycle: got %0d expected %0d", name, done_cyc, exp_cyc);
    end
    tests_run++;
    if (sb_ids.size() != 0) begin
      tests_failed++;
      $display("FAIL %s missing spikes: got %0d left expected 0", name, sb_ids.size());
      sb_ids.delete();
    end
    // after done: back in IDLE, no repeat pulse, nothing outstanding
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if ({done, busy, spike_valid} !== 3'b000) begin
        tests_failed++;
        $display("FAIL %s idle after done: got done/busy/valid=%b expected 000",
                 name, {done, busy, spike_valid});
      end
      step();
    end
    tests_run++;
    if (overrun !== exp_ovr) begin
      tests_failed++;
      $display("FAIL %s overrun: got %b expected %b", name, overrun, exp_ovr);
    end
    check_membranes(name);
    $display("[TB] %s sweep finished, done at cycle %0d", name, done_cyc);
  endtask

  task automatic test_reset();
    do_reset(2);
    tests_run++;
    if ({spike_valid, busy, done, overrun, spike_id} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset outputs: got %b expected 000000",
               {spike_valid, busy, done, overrun, spike_id});
    end
    check_membranes("reset_init");
    // load currents, start a sweep, provoke an overrun, then reset mid-sweep
    write_cur(0, 50);
    write_cur(1, 60);
    write_cur(2, 70);
    write_cur(3, 80);
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    rst = 1'b1;
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid done during reset: got %b expected 0", done);
    end
    step();
    rst = 1'b0;
    clear_model();
    tests_run++;
    if ({spike_valid, busy, done, overrun, spike_id} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_mid outputs: got %b expected 000000",
               {spike_valid, busy, done, overrun, spike_id});
    end
    check_membranes("reset_mid");
    run_sweep("after_reset", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_integrate_fire();
    write_cur(0, 100);
    run_sweep("integrate", 0, 0, 0, 0, 0, -1);
    run_sweep("fire", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    write_cur(0, 0);
    write_cur(2, 200);
    write_cur(3, 10);
    run_sweep("backpressure", 5, 0, 0, 0, 0, 3);
  endtask

  task automatic test_multi_spike();
    write_cur(0, 200);
    write_cur(1, 0);
    write_cur(2, 150);
    write_cur(3, 255);
    run_sweep("multi_spike", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_saturation();
    write_cur(0, 0);
    write_cur(1, 127);
    write_cur(2, 0);
    write_cur(3, 0);
    run_sweep("sat_prime", 0, 0, 0, 0, 0, -1);
    write_cur(1, 255);
    run_sweep("saturate", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_overrun();
    do_reset(2);
    write_cur(1, 40);
    // tick during UPDATE of neuron 1 plus a write to cur[1] in that same cycle
    exp_ovr = 1'b1;
    run_sweep("overrun", 0, 2, 2, 1, 120, -1);
    run_sweep("late_write", 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_tick_at_done();
    do_reset(2);
    exp_ovr = 1'b1;
    run_sweep("tick_at_done", 0, N + 1, 0, 0, 0, -1);
  endtask

  initial begin
    rst         = 1'b1;
    tick        = 1'b0;
    cur_we      = 1'b0;
    cur_addr    = '0;
    cur_data    = '0;
    spike_ready = 1'b1;
    state_addr  = '0;
    clear_model();
    test_reset();
    test_integrate_fire();
    test_backpressure();
    test_multi_spike();
    test_saturation();
    test_overrun();
    test_tick_at_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
Name: lif_scheduler

Overview:
- Time-multiplexes one leaky integrate-and-fire update datapath across NUM_NEURONS virtual neurons. Membrane states live in an internal register file.
- A `tick` pulse starts one timestep sweep. The sweep updates each neuron in index order and emits each spike as a valid/ready event carrying the neuron index.
- Sits between the pin-level wrapper (current loading, spike readout) and downstream spike consumers. It replaces a bank of per-neuron LIF instances.

Parameters:
- NUM_NEURONS, 4, number of virtual neurons; power of 2, min 2.
- W, 8, membrane state and input current width.
- THRESH, 128, firing threshold; a spike fires when the post-integration sum >= THRESH.
- BETA_SHIFT, 2, leak shift; leak = state >> BETA_SHIFT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  single-cycle timestep start request
- cur_we  in  1  current register write enable
- cur_addr  in  log2(NUM_NEURONS)  current register index
- cur_data  in  W  input current value
- spike_valid  out  1  spike event valid
- spike_id  out  log2(NUM_NEURONS)  index of the spiking neuron
- spike_ready  in  1  consumer accepts the spike event
- busy  out  1  a sweep is in progress
- done  out  1  one-cycle pulse at the end of a sweep
- overrun  out  1  sticky flag: a tick arrived while busy
- state_addr  in  log2(NUM_NEURONS)  membrane readout index
- state_data  out  W  combinational read of membrane[state_addr]

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all membranes and all current registers = 0; FSM = IDLE; ptr = 0; spike_valid = 0; spike_id = 0; busy = 0; done = 0; overrun = 0. Reset mid-sweep aborts the sweep with no done pulse.
- Current writes: `cur_we` writes `cur_data` to cur[cur_addr] at the clock edge, in any state. An UPDATE cycle reads the value registered before that edge, so a same-cycle write to the neuron being updated is not seen until the next sweep.
- Update arithmetic, for neuron ptr:
  - leak = m >> BETA_SHIFT
  - s = (m - leak) + cur[ptr], computed at W+1 bits and saturated to 2^W-1
  - if s >= THRESH: m <= 0 and a spike is raised; else m <= s.
- FSM states: IDLE, UPDATE, EMIT, DONE.
  - IDLE: busy = 0. tick = 1 -> UPDATE with ptr = 0.
  - UPDATE: busy = 1. Neuron ptr is written at this cycle's edge (one neuron per cycle).
    - No spike: ptr++ and stay in UPDATE, or go to DONE if ptr was NUM_NEURONS-1.
    - Spike: go to EMIT, registering spike_valid = 1 and spike_id = ptr.
  - EMIT: spike_valid and spike_id are held stable until spike_ready = 1.
    - On the handshake edge, spike_valid goes to 0 and the FSM moves to UPDATE with ptr+1, or to DONE if ptr was last.
    - spike_ready while spike_valid = 0 is ignored.
  - DONE: busy = 1 and done = 1 for exactly one cycle, then IDLE.
- Latency:
  - Tick seen in IDLE at edge t: neuron 0 is updated at edge t+1.
  - Spike-free sweep: busy is high for NUM_NEURONS+1 cycles and done is in the last of them.
  - Each spike adds one cycle plus any backpressure stall cycles.
- Boundary cases:
  - tick while busy (UPDATE/EMIT/DONE): dropped, overrun <= 1, sticky until rst. The sweep is unaffected.
  - tick in the same cycle that done is high: dropped, and the overrun flag is set.
  - At most one spike is outstanding at a time; a stalled consumer freezes the sweep indefinitely.
  - ptr wraps to 0 only through IDLE.
  - cur = 0 with m = 0 stays 0; decay can never drive m negative.
- state_data is a combinational read of the current membrane array, including during a sweep.

Test Plan:
- Reset: assert rst for 2 cycles mid-sweep -> all outputs 0 and state_data = 0 for every address; a new tick completes normally.
- Integration and fire (NUM_NEURONS=4, W=8, THRESH=128, BETA_SHIFT=2), cur[0] = 100, others 0, spike_ready tied 1:
  - tick #1 -> m0 = 100, no spike_valid, done 5 cycles after tick.
  - tick #2 -> spike_id = 0 (75 + 100 = 175 >= 128), m0 = 0, done 6 cycles after tick.
- Backpressure: cur[2] = 200, spike_ready held 0 for 5 cycles -> spike_valid and spike_id = 2 stable throughout; neuron 3 not updated until the cycle after ready; done follows.
- Multiple spikes in one sweep: cur = {200, 0, 150, 255} -> events in order id 0, 2, 3; m0, m2, m3 = 0; m1 = 0.
- Saturation: write cur[1] = 127 and set m1 = 127 via a prior sweep; then cur[1] = 255 -> s saturates to 255, spike on id 1, m1 = 0 with no wrap artefacts.
- Overrun and concurrent writes:
  - tick pulsed during UPDATE -> overrun = 1 and only one done pulse.
  - cur_we to the neuron being updated in its UPDATE cycle -> the old value is used; the new value takes effect next sweep.
